// File: rtl/bcd_stopwatch_pkg.sv
// bcd_stopwatch_pkg: state encoding and BCD digit limits shared by the stopwatch files
package bcd_stopwatch_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;
  localparam logic [3:0] SEC_ONES_MAX = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] MIN_ONES_MAX = 4'd9;
  localparam logic [3:0] MIN_TENS_MAX = 4'd9;
endpackage

// File: rtl/bcd_stopwatch_digit_counter.sv
// bcd_digit_counter: one BCD digit of the stopwatch, 0..MAX with a same-cycle carry out
module bcd_digit_counter #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iClr,
  input  logic       iInc,
  output logic [3:0] oDigit,
  output logic       oCarry
);
  logic [3:0] digit_q, digit_d;
  always_comb digit_d = iClr ? 4'd0 : !iInc ? digit_q : (digit_q == MAX) ? 4'd0 : digit_q + 4'd1;
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) digit_q <= 4'd0;
    else         digit_q <= digit_d;
  assign oCarry = iInc && (digit_q == MAX);
  assign oDigit = digit_q;
endmodule

// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: MM:SS BCD stopwatch with start/stop and clear buttons and a run/pause/idle FSM
module bcd_stopwatch
  import bcd_stopwatch_pkg::*;
#(
  parameter int MIN_LIMIT   = 59,
  parameter int SYNC_STAGES = 2
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iTick,
  input  logic       iBtnStartStop,
  input  logic       iBtnClear,
  output logic [3:0] oSecOnes,
  output logic [3:0] oSecTens,
  output logic [3:0] oMinOnes,
  output logic [3:0] oMinTens,
  output logic       oRunning,
  output logic       oWrap
);
  localparam logic [3:0] LIM_TENS = 4'(MIN_LIMIT / 10);
  localparam logic [3:0] LIM_ONES = 4'(MIN_LIMIT % 10);
  logic [SYNC_STAGES-1:0] ss_sync_q, clr_sync_q;
  logic ss_prev_q, clr_prev_q;
  logic ss_evt, clr_evt;
  state_e state_q;
  logic wrap_q, wrap_d;
  logic inc, at_limit, dig_clr;
  logic c_so, c_st, c_mo, c_mt;
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) begin
      ss_sync_q  <= '0;
      clr_sync_q <= '0;
      ss_prev_q  <= 1'b0;
      clr_prev_q <= 1'b0;
    end else begin
      ss_sync_q  <= {ss_sync_q[SYNC_STAGES-2:0], iBtnStartStop};
      clr_sync_q <= {clr_sync_q[SYNC_STAGES-2:0], iBtnClear};
      ss_prev_q  <= ss_sync_q[SYNC_STAGES-1];
      clr_prev_q <= clr_sync_q[SYNC_STAGES-1];
    end
  assign ss_evt  = ss_sync_q[SYNC_STAGES-1] && !ss_prev_q;
  assign clr_evt = clr_sync_q[SYNC_STAGES-1] && !clr_prev_q;
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n)      state_q <= ST_IDLE;
    else if (clr_evt) state_q <= ST_IDLE;
    else if (ss_evt)  state_q <= (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
  // A tick in the cycle that leaves RUN still counts; a coincident clear drops it
  assign inc      = iTick && (state_q == ST_RUN) && !clr_evt;
  assign at_limit = (oMinTens == LIM_TENS) && (oMinOnes == LIM_ONES) &&
                    (oSecTens == SEC_TENS_MAX) && (oSecOnes == SEC_ONES_MAX);
  assign wrap_d   = inc && at_limit;
  assign dig_clr  = clr_evt || wrap_d || c_mt;
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) wrap_q <= 1'b0;
    else         wrap_q <= wrap_d;
  bcd_digit_counter #(.MAX(SEC_ONES_MAX)) u_sec_ones (
    .iClk(iClk), .iRst_n(iRst_n), .iClr(dig_clr), .iInc(inc),  .oDigit(oSecOnes), .oCarry(c_so));
  bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .iClk(iClk), .iRst_n(iRst_n), .iClr(dig_clr), .iInc(c_so), .oDigit(oSecTens), .oCarry(c_st));
  bcd_digit_counter #(.MAX(MIN_ONES_MAX)) u_min_ones (
    .iClk(iClk), .iRst_n(iRst_n), .iClr(dig_clr), .iInc(c_st), .oDigit(oMinOnes), .oCarry(c_mo));
  bcd_digit_counter #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .iClk(iClk), .iRst_n(iRst_n), .iClr(dig_clr), .iInc(c_mo), .oDigit(oMinTens), .oCarry(c_mt));
  assign oRunning = (state_q == ST_RUN);
  assign oWrap    = wrap_q;
endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb_bcd_stopwatch: randomized scenarios against a seconds-count model, default and MIN_LIMIT=2 instances
module tb_bcd_stopwatch;
  localparam int SS = 2;
  logic clk = 1'b0;
  logic rst_n, tick_i, ss_i, clr_i;
  logic [3:0] a_so, a_st, a_mo, a_mt, b_so, b_st, b_mo, b_mt;
  logic a_run, a_wrap, b_run, b_wrap;
  int checks = 0, errors = 0;
  int secs_a = 0, secs_b = 0;
  bit run_m = 0;
  int wraps_a = 0, wraps_b = 0, dbl_wrap = 0;
  logic a_wrap_p = 0, b_wrap_p = 0;
  wire [15:0] cnt_a = {a_mt, a_mo, a_st, a_so};
  wire [15:0] cnt_b = {b_mt, b_mo, b_st, b_so};
  always #5 clk = ~clk;
  bcd_stopwatch #(.MIN_LIMIT(59), .SYNC_STAGES(SS)) dut_a (
    .iClk(clk), .iRst_n(rst_n), .iTick(tick_i), .iBtnStartStop(ss_i), .iBtnClear(clr_i),
    .oSecOnes(a_so), .oSecTens(a_st), .oMinOnes(a_mo), .oMinTens(a_mt),
    .oRunning(a_run), .oWrap(a_wrap));
  bcd_stopwatch #(.MIN_LIMIT(2), .SYNC_STAGES(SS)) dut_b (
    .iClk(clk), .iRst_n(rst_n), .iTick(tick_i), .iBtnStartStop(ss_i), .iBtnClear(clr_i),
    .oSecOnes(b_so), .oSecTens(b_st), .oMinOnes(b_mo), .oMinTens(b_mt),
    .oRunning(b_run), .oWrap(b_wrap));
  always @(negedge clk) begin
    if (a_wrap) wraps_a++;
    if (b_wrap) wraps_b++;
    if ((a_wrap && a_wrap_p) || (b_wrap && b_wrap_p)) dbl_wrap++;
    a_wrap_p <= a_wrap;
    b_wrap_p <= b_wrap;
  end
  function automatic logic [15:0] bcd(int s);
    int m, x;
    m = s / 60;
    x = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction
  task automatic cyc();
    @(negedge clk);
  endtask
  task automatic tick();
    tick_i = 1'b1;
    cyc();
    tick_i = 1'b0;
    if (run_m) begin
      secs_a = (secs_a + 1) % 3600;
      secs_b = (secs_b + 1) % 180;
    end
  endtask
  task automatic run_ticks(int n);
    for (int i = 0; i < n; i++) begin
      tick();
      repeat ($urandom_range(0, 3)) cyc();
    end
  endtask
  task automatic press_ss();
    ss_i = 1'b1;
    repeat (SS + 1) cyc();
    ss_i = 1'b0;
    run_m = !run_m;
    repeat (SS + 1) cyc();
  endtask
  task automatic press_clr();
    clr_i = 1'b1;
    repeat (SS + 1) cyc();
    clr_i = 1'b0;
    run_m = 0;
    secs_a = 0;
    secs_b = 0;
    repeat (SS + 1) cyc();
  endtask
  task automatic test_reset();
    rst_n = 1'b0; tick_i = 1'b0; ss_i = 1'b0; clr_i = 1'b0;
    repeat (3) cyc();
    checks++;
    if ({cnt_a, cnt_b, a_run, a_wrap, b_run, b_wrap} !== 36'd0) begin
      errors++; $display("FAIL reset_hold: got a=%h b=%h run=%b%b wrap=%b%b want all 0", cnt_a, cnt_b, a_run, b_run, a_wrap, b_wrap);
    end
    rst_n = 1'b1;
    repeat (2) cyc();
    checks++;
    if ({cnt_a, a_run, a_wrap} !== 18'd0) begin
      errors++; $display("FAIL reset_release: got a=%h run=%b wrap=%b want 0", cnt_a, a_run, a_wrap);
    end
  endtask
  task automatic test_count();
    int w0;
    w0 = wraps_a + wraps_b;
    press_ss();
    run_ticks(125);
    checks++;
    if (cnt_a !== 16'h0205 || cnt_a !== bcd(secs_a)) begin
      errors++; $display("FAIL count_125: got %h want 0205 (model %h)", cnt_a, bcd(secs_a));
    end
    checks++;
    if (a_run !== 1'b1 || b_run !== 1'b1) begin
      errors++; $display("FAIL count_running: got %b%b want 11", a_run, b_run);
    end
    checks++;
    if (wraps_a + wraps_b !== w0) begin
      errors++; $display("FAIL count_no_wrap: got %0d wrap pulses want 0", wraps_a + wraps_b - w0);
    end
  endtask
  task automatic test_carry();
    press_clr();
    press_ss();
    run_ticks(59);
    checks++;
    if (cnt_a !== 16'h0059) begin errors++; $display("FAIL carry_0059: got %h want 0059", cnt_a); end
    tick();
    checks++;
    if (cnt_a !== 16'h0100) begin errors++; $display("FAIL carry_0100: got %h want 0100", cnt_a); end
    run_ticks(539);
    checks++;
    if (cnt_a !== 16'h0959) begin errors++; $display("FAIL carry_0959: got %h want 0959", cnt_a); end
    tick();
    checks++;
    if (cnt_a !== 16'h1000 || cnt_a !== bcd(secs_a)) begin
      errors++; $display("FAIL carry_1000: got %h want 1000", cnt_a);
    end
    checks++;
    if (cnt_b !== bcd(secs_b)) begin errors++; $display("FAIL carry_limit2: got %h want %h", cnt_b, bcd(secs_b)); end
  endtask
  task automatic test_wrap();
    int w0;
    press_clr();
    press_ss();
    run_ticks(179);
    checks++;
    if (cnt_b !== 16'h0259) begin errors++; $display("FAIL wrap_pre: got %h want 0259", cnt_b); end
    w0 = wraps_b;
    tick();
    checks++;
    if (cnt_b !== 16'h0000 || b_wrap !== 1'b1 || b_run !== 1'b1) begin
      errors++; $display("FAIL wrap_edge: got cnt=%h wrap=%b run=%b want 0000 1 1", cnt_b, b_wrap, b_run);
    end
    checks++;
    if (cnt_a !== 16'h0300 || a_wrap !== 1'b0) begin
      errors++; $display("FAIL wrap_other: got cnt=%h wrap=%b want 0300 0", cnt_a, a_wrap);
    end
    cyc();
    checks++;
    if (b_wrap !== 1'b0 || wraps_b !== w0 + 1) begin
      errors++; $display("FAIL wrap_width: got wrap=%b pulses=%0d want 0 1", b_wrap, wraps_b - w0);
    end
    run_ticks(4);
    checks++;
    if (cnt_b !== bcd(secs_b) || cnt_b !== 16'h0004) begin
      errors++; $display("FAIL wrap_after: got %h want 0004", cnt_b);
    end
  endtask
  task automatic test_pause();
    press_clr();
    press_ss();
    run_ticks($urandom_range(5, 200));
    ss_i = 1'b1;
    repeat (SS) cyc();
    tick();
    run_m = 0;
    checks++;
    if (cnt_a !== bcd(secs_a) || a_run !== 1'b0) begin
      errors++; $display("FAIL pause_tick: got cnt=%h run=%b want %h 0", cnt_a, a_run, bcd(secs_a));
    end
    ss_i = 1'b0;
    repeat (SS + 1) cyc();
    run_ticks(10);
    checks++;
    if (cnt_a !== bcd(secs_a) || cnt_b !== bcd(secs_b)) begin
      errors++; $display("FAIL pause_hold: got a=%h b=%h want %h %h", cnt_a, cnt_b, bcd(secs_a), bcd(secs_b));
    end
    press_ss();
    run_ticks(3);
    checks++;
    if (cnt_a !== bcd(secs_a) || a_run !== 1'b1) begin
      errors++; $display("FAIL pause_resume: got cnt=%h run=%b want %h 1", cnt_a, a_run, bcd(secs_a));
    end
  endtask
  task automatic test_clear();
    press_clr();
    press_ss();
    run_ticks(197);
    checks++;
    if (cnt_a !== 16'h0317) begin errors++; $display("FAIL clear_pre: got %h want 0317", cnt_a); end
    clr_i = 1'b1;
    repeat (SS) cyc();
    tick_i = 1'b1;
    cyc();
    tick_i = 1'b0;
    secs_a = 0; secs_b = 0; run_m = 0;
    checks++;
    if (cnt_a !== 16'h0000 || cnt_b !== 16'h0000 || a_run !== 1'b0) begin
      errors++; $display("FAIL clear_tick: got a=%h b=%h run=%b want 0000 0000 0", cnt_a, cnt_b, a_run);
    end
    press_ss();
    run_ticks(20);
    repeat (1000) cyc();
    checks++;
    if (cnt_a !== 16'h0020 || cnt_a !== bcd(secs_a) || a_run !== 1'b1) begin
      errors++; $display("FAIL clear_held: got cnt=%h run=%b want 0020 1", cnt_a, a_run);
    end
    clr_i = 1'b0;
    repeat (SS + 2) cyc();
    checks++;
    if (a_run !== 1'b1 || cnt_a !== bcd(secs_a)) begin
      errors++; $display("FAIL clear_release: got cnt=%h run=%b want %h 1", cnt_a, a_run, bcd(secs_a));
    end
  endtask
  task automatic test_async_reset();
    press_clr();
    press_ss();
    run_ticks(462);
    checks++;
    if (cnt_a !== 16'h0742) begin errors++; $display("FAIL areset_pre: got %h want 0742", cnt_a); end
    #3 rst_n = 1'b0;
    #1;
    secs_a = 0; secs_b = 0; run_m = 0;
    checks++;
    if ({cnt_a, cnt_b, a_run, a_wrap, b_run, b_wrap} !== 36'd0) begin
      errors++; $display("FAIL areset_now: got a=%h b=%h run=%b%b want all 0", cnt_a, cnt_b, a_run, b_run);
    end
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    run_ticks(3);
    checks++;
    if (cnt_a !== 16'h0000 || cnt_b !== 16'h0000 || a_run !== 1'b0) begin
      errors++; $display("FAIL areset_after: got a=%h b=%h run=%b want 0000 0000 0", cnt_a, cnt_b, a_run);
    end
  endtask
  initial begin
    test_reset();
    test_count();
    test_carry();
    test_wrap();
    test_pause();
    test_clear();
    test_async_reset();
    checks++;
    if (dbl_wrap !== 0) begin errors++; $display("FAIL wrap_consecutive: got %0d want 0", dbl_wrap); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
